// File: rtl/iob_ibex_axi_rd_arb.sv
// 2:1 round-robin AXI4 read-channel arbiter for the Ibex ibus/dbus bridges.
// One outstanding read at a time; the R channel is a combinational pass-through gated by the grant.
//
// Handshakes: every AR and R transfer completes on a rising clk_i edge where valid and ready are
// both high and cke_i=1. A requester keeps arvalid and its payload stable until it sees arready.
module iob_ibex_axi_rd_arb #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_ni,

    input  logic [AXI_ADDR_W-3:0] ibus_axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  ibus_axi_arlen_i,
    input  logic                  ibus_axi_arvalid_i,
    output logic                  ibus_axi_arready_o,
    output logic [AXI_DATA_W-1:0] ibus_axi_rdata_o,
    output logic [1:0]            ibus_axi_rresp_o,
    output logic                  ibus_axi_rlast_o,
    output logic                  ibus_axi_rvalid_o,
    input  logic                  ibus_axi_rready_i,

    input  logic [AXI_ADDR_W-3:0] dbus_axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  dbus_axi_arlen_i,
    input  logic                  dbus_axi_arvalid_i,
    output logic                  dbus_axi_arready_o,
    output logic [AXI_DATA_W-1:0] dbus_axi_rdata_o,
    output logic [1:0]            dbus_axi_rresp_o,
    output logic                  dbus_axi_rlast_o,
    output logic                  dbus_axi_rvalid_o,
    input  logic                  dbus_axi_rready_i,

    output logic [AXI_ADDR_W-3:0] m_axi_araddr_o,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen_o,
    output logic [AXI_ID_W-1:0]   m_axi_arid_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rlast_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o,

    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;   // 0 = ibus, 1 = dbus
    logic   lst_q, lst_d;   // requester that won the previous address phase
    logic   rready_sel;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            lst_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            lst_q   <= lst_d;
        end
    end

    assign rready_sel = gnt_q ? dbus_axi_rready_i : ibus_axi_rready_i;

    always_comb begin
        state_d            = state_q;
        gnt_d              = gnt_q;
        lst_d              = lst_q;
        m_axi_arvalid_o    = 1'b0;
        m_axi_rready_o     = 1'b0;
        ibus_axi_arready_o = 1'b0;
        dbus_axi_arready_o = 1'b0;
        ibus_axi_rvalid_o  = 1'b0;
        dbus_axi_rvalid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ibus_axi_arvalid_i || dbus_axi_arvalid_i) begin
                    // On a tie the requester that did not win last time gets the bus.
                    if (ibus_axi_arvalid_i && dbus_axi_arvalid_i) begin
                        gnt_d = ~lst_q;
                    end else begin
                        gnt_d = dbus_axi_arvalid_i;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid_o    = 1'b1;
                ibus_axi_arready_o = ~gnt_q & m_axi_arready_i;
                dbus_axi_arready_o = gnt_q & m_axi_arready_i;
                if (m_axi_arready_i) begin
                    state_d = ST_DATA;
                    lst_d   = gnt_q;
                end
            end
            ST_DATA: begin
                m_axi_rready_o    = rready_sel;
                ibus_axi_rvalid_o = ~gnt_q & m_axi_rvalid_i;
                dbus_axi_rvalid_o = gnt_q & m_axi_rvalid_i;
                if (m_axi_rvalid_i && rready_sel && m_axi_rlast_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_axi_araddr_o   = gnt_q ? dbus_axi_araddr_i : ibus_axi_araddr_i;
    assign m_axi_arlen_o    = gnt_q ? dbus_axi_arlen_i : ibus_axi_arlen_i;
    assign m_axi_arid_o     = AXI_ID_W'(gnt_q);

    assign ibus_axi_rdata_o = m_axi_rdata_i;
    assign ibus_axi_rresp_o = m_axi_rresp_i;
    assign ibus_axi_rlast_o = m_axi_rlast_i;
    assign dbus_axi_rdata_o = m_axi_rdata_i;
    assign dbus_axi_rresp_o = m_axi_rresp_i;
    assign dbus_axi_rlast_o = m_axi_rlast_i;

    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_iob_ibex_axi_rd_arb.sv
// Directed bench for iob_ibex_axi_rd_arb: transaction-level reference model checked every cycle,
// plus an arid scoreboard and literal expectations for each scenario.
module tb_iob_ibex_axi_rd_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 1;
    localparam int PW = AW - 2;

    logic          clk, cke, arst_n;
    logic [PW-1:0] i_addr, d_addr, m_araddr;
    logic [LW-1:0] i_len, d_len, m_arlen;
    logic          i_arv, d_arv, i_arr, d_arr;
    logic [DW-1:0] i_rdata, d_rdata, m_rdata;
    logic [1:0]    i_rresp, d_rresp, m_rresp;
    logic          i_rlast, d_rlast, m_rlast;
    logic          i_rv, d_rv, i_rr, d_rr;
    logic [IW-1:0] m_arid;
    logic          m_arv, m_arr, m_rv, m_rr;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] exp_q[$];

    // model: phase 0 = no transaction, 1 = address offered, 2 = data returning
    int mphase = 0;
    int mowner = 0;
    int mlast  = 0;

    iob_ibex_axi_rd_arb #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)
    ) dut (
        .clk_i(clk), .cke_i(cke), .arst_ni(arst_n),
        .ibus_axi_araddr_i(i_addr), .ibus_axi_arlen_i(i_len), .ibus_axi_arvalid_i(i_arv),
        .ibus_axi_arready_o(i_arr), .ibus_axi_rdata_o(i_rdata), .ibus_axi_rresp_o(i_rresp),
        .ibus_axi_rlast_o(i_rlast), .ibus_axi_rvalid_o(i_rv), .ibus_axi_rready_i(i_rr),
        .dbus_axi_araddr_i(d_addr), .dbus_axi_arlen_i(d_len), .dbus_axi_arvalid_i(d_arv),
        .dbus_axi_arready_o(d_arr), .dbus_axi_rdata_o(d_rdata), .dbus_axi_rresp_o(d_rresp),
        .dbus_axi_rlast_o(d_rlast), .dbus_axi_rvalid_o(d_rv), .dbus_axi_rready_i(d_rr),
        .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen), .m_axi_arid_o(m_arid),
        .m_axi_arvalid_o(m_arv), .m_axi_arready_i(m_arr), .m_axi_rdata_i(m_rdata),
        .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast), .m_axi_rvalid_i(m_rv),
        .m_axi_rready_o(m_rr), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one transaction at a time, ties go to whoever did not win last
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mphase = 0;
            mowner = 0;
            mlast  = 0;
        end else if (cke) begin
            case (mphase)
                0: if (i_arv || d_arv) begin
                    if (i_arv && d_arv) mowner = (mlast == 0) ? 1 : 0;
                    else                mowner = d_arv ? 1 : 0;
                    mphase = 1;
                end
                1: if (m_arr) begin
                    mphase = 2;
                    mlast  = mowner;
                end
                default: if (m_rv && m_rlast && ((mowner == 1) ? d_rr : i_rr)) mphase = 0;
            endcase
        end
    end

    // compare process
    always @(negedge clk) begin
        chk("cmp_state", 64'(dbg_state), 64'(mphase));
        chk("cmp_m_arvalid", 64'(m_arv), 64'(mphase == 1));
        chk("cmp_i_arready", 64'(i_arr), 64'(mphase == 1 && mowner == 0 && m_arr));
        chk("cmp_d_arready", 64'(d_arr), 64'(mphase == 1 && mowner == 1 && m_arr));
        chk("cmp_i_rvalid", 64'(i_rv), 64'(mphase == 2 && mowner == 0 && m_rv));
        chk("cmp_d_rvalid", 64'(d_rv), 64'(mphase == 2 && mowner == 1 && m_rv));
        chk("cmp_m_rready", 64'(m_rr), 64'(mphase == 2 && ((mowner == 1) ? d_rr : i_rr)));
        chk("cmp_i_rdata", 64'(i_rdata), 64'(m_rdata));
        chk("cmp_d_rdata", 64'(d_rdata), 64'(m_rdata));
        chk("cmp_rresp", 64'({i_rresp, d_rresp}), 64'({m_rresp, m_rresp}));
        chk("cmp_rlast", 64'({i_rlast, d_rlast}), 64'({m_rlast, m_rlast}));
        if (mphase == 1) begin
            chk("cmp_arid", 64'(m_arid), 64'(mowner));
            chk("cmp_araddr", 64'(m_araddr), 64'((mowner == 1) ? d_addr : i_addr));
            chk("cmp_arlen", 64'(m_arlen), 64'((mowner == 1) ? d_len : i_len));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        arst_n = 1'b0;
        i_arv = 1'b0; d_arv = 1'b0; m_arr = 1'b0; m_rv = 1'b0; m_rlast = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        step();
    endtask

    // acts as the memory for one transaction and as the granted requester dropping arvalid
    task automatic serve(input int ar_delay, input int nbeats, input int gap,
                         input logic [DW-1:0] base, input logic [PW-1:0] exp_addr);
        int n = 0;
        logic [IW-1:0] exp_id;
        while (!m_arv && n < 20) begin
            step();
            n++;
        end
        if (!m_arv) begin
            chk("ar_timeout", 64'(m_arv), 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
            return;
        end
        exp_id = exp_q.pop_front();
        chk("sb_arid", 64'(m_arid), 64'(exp_id));
        chk("sb_araddr", 64'(m_araddr), 64'(exp_addr));
        for (int i = 0; i < ar_delay; i++) begin
            step();
            chk("hold_arvalid", 64'(m_arv), 64'd1);
            chk("hold_araddr", 64'(m_araddr), 64'(exp_addr));
            chk("hold_arid", 64'(m_arid), 64'(exp_id));
        end
        m_arr = 1'b1;
        #1;
        chk("req_arready", 64'(exp_id ? d_arr : i_arr), 64'd1);
        step();
        m_arr = 1'b0;
        if (exp_id == 1'b0) i_arv = 1'b0;
        else                d_arv = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk("gap_state", 64'(dbg_state), 64'd2);
                step();
            end
            m_rv    = 1'b1;
            m_rdata = base + DW'(b);
            m_rresp = 2'(b);
            m_rlast = (b == nbeats - 1);
            #1;
            chk("beat_rdata", 64'(exp_id ? d_rdata : i_rdata), 64'(base + DW'(b)));
            chk("beat_rvalid", 64'(exp_id ? d_rv : i_rv), 64'd1);
            chk("beat_other_rvalid", 64'(exp_id ? i_rv : d_rv), 64'd0);
            step();
            m_rv    = 1'b0;
            m_rlast = 1'b0;
            chk("beat_state", 64'(dbg_state), (b == nbeats - 1) ? 64'd0 : 64'd2);
        end
    endtask

    initial begin
        arst_n = 1'b0; cke = 1'b1;
        i_addr = '0; i_len = '0; i_arv = 1'b0; i_rr = 1'b1;
        d_addr = '0; d_len = '0; d_arv = 1'b0; d_rr = 1'b1;
        m_arr = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", 64'(m_arv), 64'd0);
        chk("rst_rready", 64'(m_rr), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        arst_n = 1'b1;
        step();

        // single ibus read
        i_addr = PW'(32'h80); i_len = '0; i_arv = 1'b1; m_arr = 1'b1;
        #1;
        chk("t1_idle_arvalid", 64'(m_arv), 64'd0);
        step();
        chk("t1_arvalid", 64'(m_arv), 64'd1);
        chk("t1_arid", 64'(m_arid), 64'd0);
        chk("t1_araddr", 64'(m_araddr), 64'h80);
        chk("t1_arready", 64'(i_arr), 64'd1);
        step();
        i_arv = 1'b0; m_arr = 1'b0;
        m_rv = 1'b1; m_rdata = 32'hDEADBEEF; m_rlast = 1'b1;
        #1;
        chk("t1_rvalid", 64'(i_rv), 64'd1);
        chk("t1_rdata", 64'(i_rdata), 64'hDEADBEEF);
        chk("t1_d_rvalid", 64'(d_rv), 64'd0);
        step();
        m_rv = 1'b0; m_rlast = 1'b0;
        chk("t1_done_state", 64'(dbg_state), 64'd0);

        // simultaneous requests right after reset: dbus first, then strict alternation
        reset_pulse();
        for (int p = 0; p < 4; p++) begin
            i_addr = PW'(32'h40 + p * 8);   i_len = LW'(p);     i_arv = 1'b1;
            d_addr = PW'(32'h1000 + p * 8); d_len = LW'(p + 4); d_arv = 1'b1;
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
            serve(0, 1, 0, 32'hA000 + p * 16, PW'(32'h1000 + p * 8));
            serve(0, 1, 0, 32'hB000 + p * 16, PW'(32'h40 + p * 8));
        end
        chk("t2_sb_drained", 64'(exp_q.size()), 64'd0);

        // dbus burst of 4 with 2-cycle gaps while ibus waits
        d_addr = PW'(32'h2000); d_len = 8'd3; d_arv = 1'b1;
        i_addr = PW'(32'h2100); i_len = 8'd0; i_arv = 1'b1;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        serve(0, 4, 2, 32'hC000, PW'(32'h2000));
        serve(0, 1, 0, 32'hC100, PW'(32'h2100));

        // AR stall of 5 cycles; a late dbus request must not steal the grant
        i_addr = PW'(32'h100); i_len = 8'd1; i_arv = 1'b1;
        step();
        d_addr = PW'(32'h200); d_len = 8'd0; d_arv = 1'b1;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        serve(5, 2, 0, 32'hD000, PW'(32'h100));
        serve(0, 1, 0, 32'hD100, PW'(32'h200));

        // reset asserted mid-burst
        i_addr = PW'(32'h300); i_len = 8'd3; i_arv = 1'b1;
        step();
        m_arr = 1'b1;
        step();
        i_arv = 1'b0; m_arr = 1'b0;
        m_rv = 1'b1; m_rdata = 32'h5000; m_rlast = 1'b0;
        step();
        chk("t5_mid_state", 64'(dbg_state), 64'd2);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t5_rst_m_rready", 64'(m_rr), 64'd0);
        chk("t5_rst_i_rvalid", 64'(i_rv), 64'd0);
        chk("t5_rst_d_rvalid", 64'(d_rv), 64'd0);
        chk("t5_rst_m_arvalid", 64'(m_arv), 64'd0);
        chk("t5_rst_arready", 64'({i_arr, d_arr}), 64'd0);
        chk("t5_rst_state", 64'(dbg_state), 64'd0);
        step();
        m_rv = 1'b0;
        arst_n = 1'b1;
        step();
        i_addr = PW'(32'h340); i_len = 8'd1; i_arv = 1'b1;
        exp_q.push_back(1'b0);
        serve(0, 2, 0, 32'h6000, PW'(32'h340));

        // clock enable low for 3 cycles in the address phase
        i_addr = PW'(32'h400); i_len = 8'd0; i_arv = 1'b1;
        step();
        cke = 1'b0; m_arr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_frozen_state", 64'(dbg_state), 64'd1);
            chk("t6_frozen_arvalid", 64'(m_arv), 64'd1);
            chk("t6_frozen_arready", 64'(i_arr), 64'd1);
        end
        cke = 1'b1;
        step();
        chk("t6_state_data", 64'(dbg_state), 64'd2);
        i_arv = 1'b0; m_arr = 1'b0;
        m_rv = 1'b1; m_rdata = 32'h7000; m_rlast = 1'b1;
        #1;
        chk("t6_rvalid", 64'(i_rv), 64'd1);
        chk("t6_rdata", 64'(i_rdata), 64'h7000);
        step();
        m_rv = 1'b0; m_rlast = 1'b0;
        chk("t6_done_state", 64'(dbg_state), 64'd0);

        step();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
